// File: rtl/uart_pkg.sv
// Shared UART constants and launch FSM state type.
// Common to the TX queue and the RX/TX line blocks.
package uart_pkg;

  localparam int CLK_PER_BIT = 26;
  localparam int FRAME_BITS  = 10;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Head word is read combinationally at the read pointer.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the 8N1 transmitter start/busy handshake.
// One launch per frame; the producer only sees valid/ready.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [AW:0] level,
  output logic        empty
);

  tx_state_t  state;
  logic       full;
  logic       push;
  logic       launch;
  logic [7:0] head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign launch   = (state == IDLE) && !empty && !tx_busy;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (launch),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // ARM waits for the transmitter to acknowledge with busy before
  // WAIT can look for the end of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= ARM;
          end
        end
        ARM:     if (tx_busy) state <= WAIT;
        WAIT:    if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: TX8 line model, serial decoder and
// a queue-based reference for order, occupancy and launch rules.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int FRAME = 260;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // TX8 model: samples start, raises busy, shifts {stop,data,start}
  logic       mbusy = 1'b0;
  logic       line = 1'b1;
  logic       hold = 1'b0;
  logic       late = 1'b0;
  logic [9:0] frm = '1;
  int         bcnt = 0;
  int         pend = 0;

  assign tx_busy = mbusy | hold;

  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      line  <= 1'b1;
      pend  <= 0;
      bcnt  <= 0;
    end else if (pend > 0) begin
      if (pend == 1) begin
        mbusy <= 1'b1;
        line  <= frm[0];
        bcnt  <= 0;
      end
      pend <= pend - 1;
    end else if (mbusy) begin
      if (bcnt == FRAME - 1) begin
        mbusy <= 1'b0;
        line  <= 1'b1;
      end else begin
        bcnt <= bcnt + 1;
        line <= frm[(bcnt + 1) / 26];
      end
    end else if (tx_start) begin
      frm <= {1'b1, tx_data, 1'b0};
      if (late) begin
        pend <= 3;
      end else begin
        mbusy <= 1'b1;
        line  <= 1'b0;
        bcnt  <= 0;
      end
    end
  end

  // Serial decoder: mid-bit sampling of the line
  logic       dact = 1'b0;
  int         dcnt = 0;
  logic [7:0] dsh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (rst) begin
      dact <= 1'b0;
    end else if (!dact) begin
      if (line == 1'b0) begin
        dact <= 1'b1;
        dcnt <= 1;
      end
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt % 26 == 13 && dcnt / 26 >= 1 && dcnt / 26 <= 8)
        dsh[dcnt/26 - 1] <= line;
      if (dcnt == 26 * 9 + 13) begin
        rx_q.push_back(dsh);
        dact <= 1'b0;
      end
    end
  end

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         launches = 0;
  int         last_launch = -1;
  bit         spacing_on = 1'b0;
  bit         prev_start = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit         acc;
    bit         was_rst;
    logic [7:0] d;
    int         pre;
    acc     = in_valid && (exp_q.size() < DEPTH);
    was_rst = rst;
    d       = in_data;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      exp_q.delete();
      last_tx = 8'h00;
    end else begin
      pre = exp_q.size();
      if (acc) exp_q.push_back(d);
      if (tx_start) begin
        if (pre == 0) begin
          chk("spurious_start", 1, 0);
        end else begin
          chk("launch_data", tx_data, exp_q[0]);
          last_tx = exp_q.pop_front();
        end
        launches++;
        if (spacing_on && last_launch >= 0)
          chk("spacing", cyc - last_launch, FRAME + 3);
        last_launch = cyc;
      end
    end
    chk("level", level, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("in_ready", in_ready, exp_q.size() != DEPTH);
    chk("tx_data_hold", tx_data, last_tx);
    if (tx_start && prev_start) chk("start_twice", 1, 0);
    if (tx_start && (tx_busy || pend > 0)) chk("start_busy", 1, 0);
    prev_start = tx_start;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mbusy || pend > 0 || tx_start)
           && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic push1(logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n0;
    logic [7:0] b2b [3];
    b2b[0] = 8'hA1;
    b2b[1] = 8'hB2;
    b2b[2] = 8'hC3;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    tick();

    // single byte: launch one edge after the push edge
    push1(8'h55);
    chk("single_level1", level, 1);
    tick();
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'h55);
    chk("single_level0", level, 0);
    tick();
    chk("single_pulse", tx_start, 0);
    wait_idle();
    chk("single_empty", empty, 1);

    // back-to-back against the line model
    rx_q.delete();
    spacing_on  = 1'b1;
    last_launch = -1;
    foreach (b2b[i]) push1(b2b[i]);
    wait_idle();
    spacing_on = 1'b0;
    chk("b2b_rx_count", rx_q.size(), 3);
    foreach (b2b[i])
      if (i < rx_q.size()) chk("b2b_rx_byte", rx_q[i], b2b[i]);

    // fill with busy held, then drain
    rx_q.delete();
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push1(8'(i));
    chk("fill_level", level, DEPTH);
    chk("fill_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("fill_stall", level, DEPTH);
    hold = 1'b0;
    tick();
    chk("fill_first_pop", in_ready, 1);
    wait_idle();
    chk("fill_rx_count", rx_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < rx_q.size()) chk("fill_rx_byte", rx_q[i], i);

    // push in the same cycle as the launch pop
    hold = 1'b1;
    repeat (5) push1(8'($urandom));
    chk("simul_pre", level, 5);
    hold = 1'b0;
    push1(8'($urandom));
    chk("simul_start", tx_start, 1);
    chk("simul_level", level, 5);
    wait_idle();

    // reset while in WAIT with 7 queued
    repeat (8) push1(8'($urandom));
    repeat (2) tick();
    chk("mid_level", level, 7);
    chk("mid_busy", tx_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_level0", level, 0);
    chk("mid_empty", empty, 1);
    chk("mid_start", tx_start, 0);
    chk("mid_data", tx_data, 8'h00);
    chk("mid_ready", in_ready, 1);
    n0 = launches;
    repeat (40) tick();
    chk("mid_no_launch", launches, n0);

    // transmitter acknowledges late
    late = 1'b1;
    push1(8'($urandom));
    push1(8'($urandom));
    wait_idle();
    late = 1'b0;
    chk("late_empty", empty, 1);

    // random sparse traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 63) == 0);
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and launch controller between the Mandelbrot result producer and the 8N1 UART transmitter. It accepts bytes on a valid/ready interface and holds them in a DEPTH-entry FIFO. It issues them one at a time to the transmitter's start/busy handshake, so the producer never has to watch the 260-cycle frame time (10 bits × 26 clk at 24 MHz, 921,600 bps).

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- AW, log2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  synchronous, active-high reset
- in_data  in  8  byte from producer
- in_valid  in  1  producer offers in_data
- in_ready  out  1  queue accepts; transfer when in_valid && in_ready
- tx_data  out  8  byte to transmitter, registered
- tx_start  out  1  one-cycle launch pulse to transmitter, registered
- tx_busy  in  1  transmitter frame in progress
- level  out  AW+1  current FIFO occupancy, 0..DEPTH
- empty  out  1  level == 0

## Operation
- Reset values: in_ready 1, tx_data 8'h00, tx_start 0, level 0, empty 1, FSM in IDLE, pointers 0.
- in_ready = (level != DEPTH). Combinational from registered count, with no bypass: a pop in the same cycle does not raise in_ready while the FIFO is full.
- Push and pop in the same cycle leave level unchanged. Data order is strictly FIFO.
- Push while full is impossible: the producer stalls, and no data is lost or flagged.
- FSM:
  - IDLE: if !empty && !tx_busy, then tx_data <= head, tx_start <= 1, pop, go to ARM. Otherwise stay.
  - ARM: tx_start <= 0. When tx_busy == 1, go to WAIT. The transmitter raises busy on the edge after it samples start.
  - WAIT: when tx_busy == 0, go to IDLE.
- tx_start is never high in two consecutive cycles. It is never asserted while tx_busy is high or while in ARM/WAIT.
- tx_data holds its value from launch until the next launch.
- Reset mid-frame returns everything to reset values on the next edge. FIFO contents are discarded. The transmitter resets on the same rst.

## Timing
- Push at edge E into an empty queue with tx_busy low:
  - FSM sees !empty in cycle E+1.
  - tx_start is high in cycle E+2 with tx_data valid.
  - Transmitter busy rises at E+3.
- Launch-to-launch spacing with a continuously non-empty queue: the transmitter frame length (260 cycles) plus 3 cycles.
- level updates on the edge after the push/pop.
- An ARM-state wait with tx_busy never rising is a transmitter fault. The block stays in ARM, and the bench treats this as an error.

## Structure
- Shared package uart_pkg:
  - constants CLK_PER_BIT = 26, FRAME_BITS = 10
  - FSM state typedef {IDLE, ARM, WAIT}
  - RX8 and future UART blocks use the same constants.
- One sub-module, sync_fifo (DEPTH, width 8; push/pop/full/empty/level), instantiated once. The FSM and output registers live in uart_tx_queue.

## Test plan
- Single byte: push 8'h55 with tx_busy low → tx_start high for exactly 1 cycle, 2 cycles after the push edge, tx_data = 8'h55; level 1 → 0; empty returns to 1.
- Back-to-back: push 8'hA1, 8'hB2, 8'hC3 against a TX8 behavioural model → serial line carries A1, B2, C3 in order; launch spacing 263 cycles; no tx_start while tx_busy is high.
- Fill: hold tx_busy high, push 16 bytes 0x00..0x0F → level 16, in_ready 0, the 17th offer stalls. Release busy → bytes drain in order 0x00..0x0F and in_ready returns to 1 after the first pop.
- Simultaneous push/pop: level 5 in IDLE, push in the same cycle as the launch pop → level stays 5 and order is preserved.
- Reset mid-operation: assert rst for 1 cycle with level 7 during WAIT → next cycle: level 0, empty 1, tx_start 0, tx_data 8'h00, in_ready 1, and no further launch until a new push.
- Busy late: model raises tx_busy 3 cycles after start → FSM holds in ARM and issues no second tx_start; normal drain resumes once busy falls.
